riscv_core_branch_predict_unit: RTL and testbench

RISCV_CORE_BRANCH_PREDICT_UNIT -- requirements
Module: riscv_core_branch_predict_unit

---
 rtl/riscv_core_pkg.sv | 16 +
 rtl/riscv_core_branch_compare.sv | 21 ++
 rtl/riscv_core_branch_predict_unit.sv | 100 ++++++++++
 tb/tb_riscv_core_branch_predict_unit.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/riscv_core_pkg.sv
// riscv_core_pkg: branch funct3 encodings, 2-bit counter states and the saturating update shared by the core
package riscv_core_pkg;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;
  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;
  function automatic logic [1:0] bht_next(input logic [1:0] c, input logic t);
    return t ? (c == ST ? ST : c + 2'd1) : (c == SNT ? SNT : c - 2'd1);
  endfunction
endpackage

// File: rtl/riscv_core_branch_compare.sv
// riscv_core_branch_compare: evaluates a conditional branch outcome and flags reserved funct3 encodings
module riscv_core_branch_compare
  import riscv_core_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] src_a_i,
  input  logic [XLEN-1:0] src_b_i,
  input  logic [2:0]      funct3_i,
  output logic            taken_o,
  output logic            illegal_o
);
  logic eq, lt, ltu, base;
  assign eq  = src_a_i == src_b_i;
  assign lt  = $signed(src_a_i) < $signed(src_b_i);
  assign ltu = src_a_i < src_b_i;
  // funct3[2:1] picks the relation, funct3[0] inverts it (BNE/BGE/BGEU)
  assign base      = funct3_i[2] ? (funct3_i[1] ? ltu : lt) : eq;
  assign illegal_o = funct3_i[2:1] == 2'b01;
  assign taken_o   = illegal_o ? 1'b0 : base ^ funct3_i[0];
endmodule

// File: rtl/riscv_core_branch_predict_unit.sv
// riscv_core_branch_predict_unit: bimodal 2-bit BHT predictor with registered branch resolution and redirect
// Optional BRANCH_PREDICT_STATS_EN adds saturating branch/mispredict counters.
module riscv_core_branch_predict_unit
  import riscv_core_pkg::*;
#(
  parameter int XLEN        = 64,
  parameter int BHT_ENTRIES = 64
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [XLEN-1:0] i_bp_fetch_pc,
  output logic            o_bp_predict_taken,
  input  logic            i_bp_resolve_valid,
  input  logic            i_bp_flush,
  input  logic [XLEN-1:0] i_bp_resolve_pc,
  input  logic [XLEN-1:0] i_bp_srcA,
  input  logic [XLEN-1:0] i_bp_srcB,
  input  logic [2:0]      i_bp_funct3,
  input  logic [XLEN-1:0] i_bp_target,
  input  logic            i_bp_is_compressed,
  input  logic            i_bp_predicted_taken,
  output logic            o_bp_taken,
  output logic            o_bp_redirect_valid,
  output logic [XLEN-1:0] o_bp_redirect_pc,
  output logic            o_bp_illegal
`ifdef BRANCH_PREDICT_STATS_EN
  ,
  output logic [31:0]     o_bp_branch_count,
  output logic [31:0]     o_bp_mispredict_count
`endif
);
  localparam int IW = $clog2(BHT_ENTRIES);
  logic [1:0]      bht_q [BHT_ENTRIES];
  logic [IW-1:0]   look_idx, upd_idx;
  logic            cmp_taken, cmp_illegal, accept, legal, mispredict;
  logic [XLEN-1:0] fall_pc, next_pc;
  logic            taken_q, taken_d, redir_q, redir_d, ill_q, ill_d;
  logic [XLEN-1:0] rpc_q, rpc_d;
  logic            unused_fetch;
  riscv_core_branch_compare #(.XLEN(XLEN)) u_cmp (
    .src_a_i   (i_bp_srcA),
    .src_b_i   (i_bp_srcB),
    .funct3_i  (i_bp_funct3),
    .taken_o   (cmp_taken),
    .illegal_o (cmp_illegal)
  );
  // Index starts at bit 1 so compressed branches get distinct entries
  assign look_idx           = i_bp_fetch_pc[IW:1];
  assign upd_idx            = i_bp_resolve_pc[IW:1];
  assign unused_fetch       = ^{i_bp_fetch_pc[XLEN-1:IW+1], i_bp_fetch_pc[0]};
  assign o_bp_predict_taken = bht_q[look_idx][1];
  assign accept     = i_bp_resolve_valid & ~i_bp_flush;
  assign legal      = accept & ~cmp_illegal;
  assign mispredict = ~cmp_illegal & (cmp_taken != i_bp_predicted_taken);
  assign fall_pc    = i_bp_resolve_pc + (i_bp_is_compressed ? XLEN'(2) : XLEN'(4));
  assign next_pc    = cmp_taken ? i_bp_target : fall_pc;
  always_comb begin
    taken_d = accept ? cmp_taken : taken_q;
    rpc_d   = accept ? next_pc : rpc_q;
    redir_d = accept & mispredict;
    ill_d   = accept & cmp_illegal;
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= WNT;
      taken_q <= 1'b0;
      redir_q <= 1'b0;
      rpc_q   <= '0;
      ill_q   <= 1'b0;
    end else begin
      if (legal) bht_q[upd_idx] <= bht_next(bht_q[upd_idx], cmp_taken);
      taken_q <= taken_d;
      redir_q <= redir_d;
      rpc_q   <= rpc_d;
      ill_q   <= ill_d;
    end
  end
  assign o_bp_taken          = taken_q;
  assign o_bp_redirect_valid = redir_q;
  assign o_bp_redirect_pc    = rpc_q;
  assign o_bp_illegal        = ill_q;
`ifdef BRANCH_PREDICT_STATS_EN
  logic [31:0] br_cnt_q, br_cnt_d, mis_cnt_q, mis_cnt_d;
  always_comb begin
    br_cnt_d  = (legal & ~&br_cnt_q) ? br_cnt_q + 32'd1 : br_cnt_q;
    mis_cnt_d = (redir_d & ~&mis_cnt_q) ? mis_cnt_q + 32'd1 : mis_cnt_q;
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      br_cnt_q  <= '0;
      mis_cnt_q <= '0;
    end else begin
      br_cnt_q  <= br_cnt_d;
      mis_cnt_q <= mis_cnt_d;
    end
  end
  assign o_bp_branch_count     = br_cnt_q;
  assign o_bp_mispredict_count = mis_cnt_q;
`endif
endmodule

// File: tb/tb_riscv_core_branch_predict_unit.sv
// tb_riscv_core_branch_predict_unit: directed self-checking bench for the branch predict unit
module tb_riscv_core_branch_predict_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] fetch_pc = '0;
  logic        predict;
  logic        rv = 1'b0;
  logic        flush = 1'b0;
  logic [63:0] rpc_in = '0, sa = '0, sb = '0, tgt = '0;
  logic [2:0]  f3 = '0;
  logic        comp = 1'b0, pred = 1'b0;
  logic        taken, redir, ill;
  logic [63:0] rpc;
  int          vec = 0;
  int          err = 0;
`ifdef BRANCH_PREDICT_STATS_EN
  logic [31:0] bcnt, mcnt;
`endif

  riscv_core_branch_predict_unit #(.XLEN(64), .BHT_ENTRIES(64)) dut (
    .i_clk                (clk),
    .i_rst                (rst),
    .i_bp_fetch_pc        (fetch_pc),
    .o_bp_predict_taken   (predict),
    .i_bp_resolve_valid   (rv),
    .i_bp_flush           (flush),
    .i_bp_resolve_pc      (rpc_in),
    .i_bp_srcA            (sa),
    .i_bp_srcB            (sb),
    .i_bp_funct3          (f3),
    .i_bp_target          (tgt),
    .i_bp_is_compressed   (comp),
    .i_bp_predicted_taken (pred),
    .o_bp_taken           (taken),
    .o_bp_redirect_valid  (redir),
    .o_bp_redirect_pc     (rpc),
    .o_bp_illegal         (ill)
`ifdef BRANCH_PREDICT_STATS_EN
    ,
    .o_bp_branch_count    (bcnt),
    .o_bp_mispredict_count(mcnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic drive(input logic [63:0] pc, input logic [2:0] f, input logic [63:0] a, b, t,
                       input logic c, p, fl);
    rpc_in = pc; f3 = f; sa = a; sb = b; tgt = t; comp = c; pred = p; flush = fl; rv = 1'b1;
    @(posedge clk); #1;
    rv = 1'b0; flush = 1'b0;
  endtask

  task automatic test_reset;
    @(posedge clk); @(posedge clk); #1;
    vec++; if (taken !== 1'b0) begin err++; $display("FAIL reset_taken got %b exp 0", taken); end
    vec++; if (redir !== 1'b0) begin err++; $display("FAIL reset_redir got %b exp 0", redir); end
    vec++; if (rpc !== 64'h0) begin err++; $display("FAIL reset_rpc got %h exp 0", rpc); end
    vec++; if (ill !== 1'b0) begin err++; $display("FAIL reset_ill got %b exp 0", ill); end
    foreach (fetch_pc[i]) if (i < 8) begin
      fetch_pc = 64'h100 << i; #1;
      vec++; if (predict !== 1'b0) begin err++; $display("FAIL reset_predict pc %h got %b exp 0", fetch_pc, predict); end
    end
    rst = 1'b0;
  endtask

  task automatic test_beq_redirect;
    drive(64'h100, 3'b000, 64'd5, 64'd5, 64'h180, 1'b0, 1'b0, 1'b0);
    vec++; if (taken !== 1'b1) begin err++; $display("FAIL beq_taken got %b exp 1", taken); end
    vec++; if (redir !== 1'b1) begin err++; $display("FAIL beq_redir got %b exp 1", redir); end
    vec++; if (rpc !== 64'h180) begin err++; $display("FAIL beq_rpc got %h exp 180", rpc); end
    fetch_pc = 64'h100; #1;
    vec++; if (predict !== 1'b1) begin err++; $display("FAIL beq_predict got %b exp 1", predict); end
    @(posedge clk); #1;
    vec++; if (redir !== 1'b0) begin err++; $display("FAIL beq_pulse got %b exp 0", redir); end
    vec++; if (taken !== 1'b1 || rpc !== 64'h180) begin err++; $display("FAIL beq_hold got %b/%h exp 1/180", taken, rpc); end
  endtask

  task automatic test_signed_unsigned;
    drive(64'h200, 3'b100, '1, 64'd1, 64'h900, 1'b1, 1'b1, 1'b0);
    vec++; if (taken !== 1'b1) begin err++; $display("FAIL blt_taken got %b exp 1", taken); end
    vec++; if (redir !== 1'b0) begin err++; $display("FAIL blt_redir got %b exp 0", redir); end
    drive(64'h200, 3'b110, '1, 64'd1, 64'h900, 1'b1, 1'b1, 1'b0);
    vec++; if (taken !== 1'b0) begin err++; $display("FAIL bltu_taken got %b exp 0", taken); end
    vec++; if (redir !== 1'b1) begin err++; $display("FAIL bltu_redir got %b exp 1", redir); end
    vec++; if (rpc !== 64'h202) begin err++; $display("FAIL bltu_rpc got %h exp 202", rpc); end
    fetch_pc = 64'h200; #1;
    vec++; if (predict !== 1'b1) begin err++; $display("FAIL bltu_predict got %b exp 1", predict); end
  endtask

  task automatic test_saturate;
    for (int i = 0; i < 4; i++) drive(64'h40, 3'b000, 64'd7, 64'd7, 64'h80, 1'b0, 1'b1, 1'b0);
    drive(64'h40, 3'b001, 64'd7, 64'd7, 64'h80, 1'b0, 1'b1, 1'b0);
    fetch_pc = 64'h40; #1;
    vec++; if (predict !== 1'b1) begin err++; $display("FAIL sat_after_nt1 got %b exp 1", predict); end
    vec++; if (redir !== 1'b1 || rpc !== 64'h44) begin err++; $display("FAIL sat_redir got %b/%h exp 1/44", redir, rpc); end
    drive(64'h40, 3'b001, 64'd7, 64'd7, 64'h80, 1'b0, 1'b1, 1'b0);
    vec++; if (predict !== 1'b0) begin err++; $display("FAIL sat_after_nt2 got %b exp 0", predict); end
  endtask

  task automatic test_illegal_flush;
    drive(64'h8, 3'b000, 64'd1, 64'd1, 64'h20, 1'b0, 1'b0, 1'b0);
    drive(64'h8, 3'b010, 64'd1, 64'd1, 64'h20, 1'b0, 1'b1, 1'b0);
    vec++; if (ill !== 1'b1) begin err++; $display("FAIL ill_pulse got %b exp 1", ill); end
    vec++; if (taken !== 1'b0) begin err++; $display("FAIL ill_taken got %b exp 0", taken); end
    vec++; if (redir !== 1'b0) begin err++; $display("FAIL ill_redir got %b exp 0", redir); end
    fetch_pc = 64'h8; #1;
    vec++; if (predict !== 1'b1) begin err++; $display("FAIL ill_counter got %b exp 1", predict); end
    drive(64'hC, 3'b001, 64'd1, 64'd2, 64'h40, 1'b0, 1'b0, 1'b1);
    vec++; if (ill !== 1'b0 || redir !== 1'b0) begin err++; $display("FAIL flush_pulses got %b/%b exp 0/0", ill, redir); end
    vec++; if (taken !== 1'b0) begin err++; $display("FAIL flush_taken got %b exp 0", taken); end
    fetch_pc = 64'hC; #1;
    vec++; if (predict !== 1'b0) begin err++; $display("FAIL flush_counter got %b exp 0", predict); end
  endtask

  task automatic test_back_to_back;
    fetch_pc = 64'hC;
    rpc_in = 64'hC; f3 = 3'b000; sa = 64'd3; sb = 64'd3; tgt = 64'h60; comp = 1'b0; pred = 1'b0; rv = 1'b1;
    #1;
    vec++; if (predict !== 1'b0) begin err++; $display("FAIL same_idx_pre got %b exp 0", predict); end
    @(posedge clk); #1;
    vec++; if (predict !== 1'b1) begin err++; $display("FAIL same_idx_post got %b exp 1", predict); end
    rpc_in = 64'h10; f3 = 3'b001; sa = 64'd1; sb = 64'd2; tgt = 64'h300;
    @(posedge clk); #1;
    vec++; if (redir !== 1'b1 || rpc !== 64'h300) begin err++; $display("FAIL b2b_first got %b/%h exp 1/300", redir, rpc); end
    f3 = 3'b101;
    @(posedge clk); #1;
    rv = 1'b0;
    vec++; if (redir !== 1'b0 || taken !== 1'b0 || rpc !== 64'h14) begin err++; $display("FAIL b2b_second got %b/%b/%h exp 0/0/14", redir, taken, rpc); end
  endtask

  task automatic test_reset_mid;
    rpc_in = 64'h100; f3 = 3'b000; sa = 64'd9; sb = 64'd9; tgt = 64'h700; pred = 1'b0; rv = 1'b1;
    #2 rst = 1'b1; #1;
    vec++; if (taken !== 1'b0 || rpc !== 64'h0) begin err++; $display("FAIL mid_rst_async got %b/%h exp 0/0", taken, rpc); end
    @(posedge clk); #1;
    rv = 1'b0; rst = 1'b0;
    vec++; if (redir !== 1'b0 || ill !== 1'b0) begin err++; $display("FAIL mid_rst_pulses got %b/%b exp 0/0", redir, ill); end
    fetch_pc = 64'h100; #1;
    vec++; if (predict !== 1'b0) begin err++; $display("FAIL mid_rst_bht got %b exp 0", predict); end
    drive(64'h100, 3'b111, 64'd5, 64'd3, 64'h500, 1'b0, 1'b1, 1'b0);
    vec++; if (taken !== 1'b1 || redir !== 1'b0 || rpc !== 64'h500) begin err++; $display("FAIL post_rst got %b/%b/%h exp 1/0/500", taken, redir, rpc); end
    vec++; if (predict !== 1'b1) begin err++; $display("FAIL post_rst_predict got %b exp 1", predict); end
  endtask

`ifdef BRANCH_PREDICT_STATS_EN
  task automatic test_stats;
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    drive(64'h20, 3'b000, 64'd4, 64'd4, 64'h90, 1'b0, 1'b1, 1'b0);
    drive(64'h20, 3'b001, 64'd4, 64'd4, 64'h90, 1'b0, 1'b0, 1'b0);
    drive(64'h20, 3'b110, 64'd1, 64'd2, 64'h90, 1'b0, 1'b0, 1'b0);
    drive(64'h20, 3'b011, 64'd1, 64'd2, 64'h90, 1'b0, 1'b1, 1'b0);
    vec++; if (bcnt !== 32'd3) begin err++; $display("FAIL stats_branch got %0d exp 3", bcnt); end
    vec++; if (mcnt !== 32'd1) begin err++; $display("FAIL stats_mispredict got %0d exp 1", mcnt); end
    #2 rst = 1'b1; #1;
    vec++; if (bcnt !== 32'd0 || mcnt !== 32'd0) begin err++; $display("FAIL stats_reset got %0d/%0d exp 0/0", bcnt, mcnt); end
    @(posedge clk); #1; rst = 1'b0;
  endtask
`endif

  initial begin
    test_reset;
    test_beq_redirect;
    test_signed_unsigned;
    test_saturate;
    test_illegal_flush;
    test_back_to_back;
    test_reset_mid;
`ifdef BRANCH_PREDICT_STATS_EN
    test_stats;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
